// File: rtl/game_pkg.sv
// Shared types and constants for the match referee and its tally counters.
package game_pkg;

  localparam int unsigned TallyW = 4;

  typedef enum logic [1:0] {
    WHO_NONE   = 2'b00,
    WHO_LOSER  = 2'b01,
    WHO_WINNER = 2'b10,
    WHO_BAD    = 2'b11
  } who_t;

  typedef enum logic [1:0] {
    StIdle,
    StPlay,
    StClearing,
    StDone
  } ref_state_t;

endpackage

// File: rtl/game_referee_if.sv
// Referee-to-counter/host signal bundle; timeout exists only with REFEREE_TIMEOUT_EN.
interface game_referee_if import game_pkg::*; ();

  logic              start_match;
  logic              gameover;
  logic [1:0]        who;
  logic              counter_clear;
  logic [TallyW-1:0] loser_wins;
  logic [TallyW-1:0] winner_wins;
  logic              match_done;
  logic [1:0]        match_winner;
  logic              bad_who;
`ifdef REFEREE_TIMEOUT_EN
  logic              timeout;
`endif

  modport master (
    output start_match, gameover, who,
    input  counter_clear, loser_wins, winner_wins, match_done, match_winner, bad_who
`ifdef REFEREE_TIMEOUT_EN
    , input timeout
`endif
  );

  modport slave (
    input  start_match, gameover, who,
    output counter_clear, loser_wins, winner_wins, match_done, match_winner, bad_who
`ifdef REFEREE_TIMEOUT_EN
    , output timeout
`endif
  );

endinterface

// File: rtl/win_tally.sv
// Per-side game counter: synchronous clear, increment enable, saturates at Limit.
module win_tally import game_pkg::*; #(
  parameter int unsigned Limit = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              inc,
  output logic [TallyW-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (inc && (count != TallyW'(Limit))) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/game_referee.sv
// Best-of-N match referee driving the game counter's clear input.
// Optional watchdog enabled by defining REFEREE_TIMEOUT_EN.
module game_referee import game_pkg::*; #(
  parameter int unsigned GAMES_TO_WIN = 3,
  parameter int unsigned CLEAR_CYCLES = 2
`ifdef REFEREE_TIMEOUT_EN
  , parameter int unsigned TIMEOUT_CYCLES = 1024
`endif
) (
  input logic           clk,
  input logic           rst,
  game_referee_if.slave bus
);

  localparam int unsigned ClrW = $clog2(CLEAR_CYCLES + 1);

  ref_state_t        state;
  logic              gameover_q;
  logic [ClrW-1:0]   clear_cnt;
  logic              counter_clear_q;
  logic              match_done_q;
  logic [1:0]        match_winner_q;
  logic              bad_who_q;
  logic [TallyW-1:0] loser_cnt;
  logic [TallyW-1:0] winner_cnt;

  logic game_end;
  logic who_valid;
  logic tally_clear;
  logic loser_full;
  logic winner_full;

  assign game_end    = (state == StPlay) && bus.gameover && !gameover_q;
  assign who_valid   = (bus.who == WHO_LOSER) || (bus.who == WHO_WINNER);
  assign tally_clear = bus.start_match && ((state == StIdle) || (state == StDone));
  assign loser_full  = (loser_cnt == TallyW'(GAMES_TO_WIN));
  assign winner_full = (winner_cnt == TallyW'(GAMES_TO_WIN));

`ifdef REFEREE_TIMEOUT_EN
  localparam int unsigned WdW = $clog2(TIMEOUT_CYCLES + 1);
  logic [WdW-1:0] wdog;
  logic           timeout_q;
  assign bus.timeout = timeout_q;
`endif

  win_tally #(.Limit(GAMES_TO_WIN)) u_loser_tally (
    .clk   (clk),
    .rst   (rst),
    .clear (tally_clear),
    .inc   (game_end && (bus.who == WHO_LOSER)),
    .count (loser_cnt)
  );

  win_tally #(.Limit(GAMES_TO_WIN)) u_winner_tally (
    .clk   (clk),
    .rst   (rst),
    .clear (tally_clear),
    .inc   (game_end && (bus.who == WHO_WINNER)),
    .count (winner_cnt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= StIdle;
      gameover_q      <= 1'b0;
      clear_cnt       <= '0;
      counter_clear_q <= 1'b1;
      match_done_q    <= 1'b0;
      match_winner_q  <= WHO_NONE;
      bad_who_q       <= 1'b0;
`ifdef REFEREE_TIMEOUT_EN
      wdog            <= '0;
      timeout_q       <= 1'b0;
`endif
    end else begin
      bad_who_q  <= 1'b0;
      gameover_q <= bus.gameover;
      unique case (state)
        StIdle: begin
          counter_clear_q <= 1'b1;
          if (bus.start_match) begin
            state     <= StClearing;
            clear_cnt <= ClrW'(CLEAR_CYCLES - 1);
`ifdef REFEREE_TIMEOUT_EN
            timeout_q <= 1'b0;
`endif
          end
        end
        StPlay: begin
          if (game_end) begin
            state           <= StClearing;
            counter_clear_q <= 1'b1;
            clear_cnt       <= ClrW'(CLEAR_CYCLES - 1);
            bad_who_q       <= !who_valid;
          end
`ifdef REFEREE_TIMEOUT_EN
          else if (wdog == WdW'(TIMEOUT_CYCLES - 1)) begin
            state           <= StClearing;
            counter_clear_q <= 1'b1;
            clear_cnt       <= ClrW'(CLEAR_CYCLES - 1);
            timeout_q       <= 1'b1;
          end else begin
            wdog <= wdog + 1'b1;
          end
`endif
        end
        StClearing: begin
          if (clear_cnt == '0) begin
            if (loser_full || winner_full) begin
              state          <= StDone;
              match_done_q   <= 1'b1;
              match_winner_q <= loser_full ? WHO_LOSER : WHO_WINNER;
            end else begin
              state           <= StPlay;
              counter_clear_q <= 1'b0;
              // A gameover already high on entry must not look like a new edge.
              gameover_q      <= 1'b1;
`ifdef REFEREE_TIMEOUT_EN
              wdog            <= '0;
`endif
            end
          end else begin
            clear_cnt <= clear_cnt - 1'b1;
          end
        end
        StDone: begin
          counter_clear_q <= 1'b1;
          if (bus.start_match) begin
            state          <= StClearing;
            clear_cnt      <= ClrW'(CLEAR_CYCLES - 1);
            match_done_q   <= 1'b0;
            match_winner_q <= WHO_NONE;
`ifdef REFEREE_TIMEOUT_EN
            timeout_q      <= 1'b0;
`endif
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

  assign bus.counter_clear = counter_clear_q;
  assign bus.loser_wins    = loser_cnt;
  assign bus.winner_wins   = winner_cnt;
  assign bus.match_done    = match_done_q;
  assign bus.match_winner  = match_winner_q;
  assign bus.bad_who       = bad_who_q;

endmodule

// File: tb/tb_game_referee.sv
// Directed bench for game_referee: expected per-game results go through a scoreboard queue.
module tb_game_referee;

  localparam int unsigned G = 3;

  typedef struct {
    logic [3:0] lw;
    logic [3:0] ww;
    logic       bad;
    logic       done;
    logic [1:0] winner;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;
  int   exp_l = 0;
  int   exp_w = 0;
  exp_t sb[$];

  game_referee_if bus ();

`ifdef REFEREE_TIMEOUT_EN
  game_referee #(.GAMES_TO_WIN(G), .CLEAR_CYCLES(2), .TIMEOUT_CYCLES(16)) dut (
`else
  game_referee #(.GAMES_TO_WIN(G), .CLEAR_CYCLES(2)) dut (
`endif
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge of the first PLAY cycle.
  task automatic start_seq();
    bus.start_match = 1'b1;
    @(negedge clk);
    bus.start_match = 1'b0;
    exp_l = 0;
    exp_w = 0;
    check("start_clr1", {7'd0, bus.counter_clear}, 8'd1);
    check("start_done", {7'd0, bus.match_done}, 8'd0);
    check("start_win", {6'd0, bus.match_winner}, 8'd0);
    check("start_lw", {4'd0, bus.loser_wins}, 8'd0);
    check("start_ww", {4'd0, bus.winner_wins}, 8'd0);
    @(negedge clk);
    check("start_clr2", {7'd0, bus.counter_clear}, 8'd1);
    @(negedge clk);
    check("start_play", {7'd0, bus.counter_clear}, 8'd0);
  endtask

  // One game in PLAY: one quiet cycle, then a gameover edge with code w.
  task automatic play_game(input logic [1:0] w);
    exp_t e;
    @(negedge clk);
    if (w == 2'b01 && exp_l < int'(G)) exp_l++;
    else if (w == 2'b10 && exp_w < int'(G)) exp_w++;
    e.lw     = 4'(exp_l);
    e.ww     = 4'(exp_w);
    e.bad    = (w == 2'b00) || (w == 2'b11);
    e.done   = (exp_l == int'(G)) || (exp_w == int'(G));
    e.winner = (exp_l == int'(G)) ? 2'b01 : (exp_w == int'(G)) ? 2'b10 : 2'b00;
    sb.push_back(e);
    bus.who      = w;
    bus.gameover = 1'b1;
    @(negedge clk);
    e = sb.pop_front();
    bus.gameover = 1'b0;
    check("game_clr1", {7'd0, bus.counter_clear}, 8'd1);
    check("game_bad", {7'd0, bus.bad_who}, {7'd0, e.bad});
    check("game_lw", {4'd0, bus.loser_wins}, {4'd0, e.lw});
    check("game_ww", {4'd0, bus.winner_wins}, {4'd0, e.ww});
    @(negedge clk);
    check("game_clr2", {7'd0, bus.counter_clear}, 8'd1);
    check("game_bad_end", {7'd0, bus.bad_who}, 8'd0);
    @(negedge clk);
    check("game_exit_clr", {7'd0, bus.counter_clear}, {7'd0, e.done});
    check("game_done", {7'd0, bus.match_done}, {7'd0, e.done});
    check("game_winner", {6'd0, bus.match_winner}, {6'd0, e.winner});
  endtask

  initial begin
    rst             = 1'b1;
    bus.start_match = 1'b0;
    bus.gameover    = 1'b0;
    bus.who         = 2'b00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("rst_clr", {7'd0, bus.counter_clear}, 8'd1);
    check("rst_lw", {4'd0, bus.loser_wins}, 8'd0);
    check("rst_ww", {4'd0, bus.winner_wins}, 8'd0);
    check("rst_done", {7'd0, bus.match_done}, 8'd0);
    check("rst_win", {6'd0, bus.match_winner}, 8'd0);
    check("rst_bad", {7'd0, bus.bad_who}, 8'd0);
    @(negedge clk);
    check("idle_clr", {7'd0, bus.counter_clear}, 8'd1);

    // Match 1: start ignored in PLAY, then a 3-0 sweep by the winner side.
    start_seq();
    bus.start_match = 1'b1;
    @(negedge clk);
    bus.start_match = 1'b0;
    check("start_in_play", {7'd0, bus.counter_clear}, 8'd0);
    repeat (3) play_game(2'b10);
    repeat (3) @(negedge clk);
    check("done_hold_clr", {7'd0, bus.counter_clear}, 8'd1);
    check("done_hold", {7'd0, bus.match_done}, 8'd1);
    bus.who      = 2'b01;
    bus.gameover = 1'b1;
    repeat (2) @(negedge clk);
    bus.gameover = 1'b0;
    check("done_frozen_lw", {4'd0, bus.loser_wins}, 8'd0);
    check("done_frozen_ww", {4'd0, bus.winner_wins}, 8'd3);

    // Match 2: restart from DONE, one invalid game, 3-2 for the loser side.
    start_seq();
    play_game(2'b01);
    play_game(2'b10);
    play_game(2'b11);
    play_game(2'b01);
    play_game(2'b10);
    play_game(2'b01);

    // Match 3: gameover held across CLEARING into PLAY, then reset mid-CLEARING.
    start_seq();
    @(negedge clk);
    bus.who      = 2'b10;
    bus.gameover = 1'b1;
    repeat (6) @(negedge clk);
    check("held_ww", {4'd0, bus.winner_wins}, 8'd1);
    check("held_play", {7'd0, bus.counter_clear}, 8'd0);
    bus.gameover = 1'b0;
    exp_w = 1;
    play_game(2'b01);
    @(negedge clk);
    bus.who      = 2'b10;
    bus.gameover = 1'b1;
    @(negedge clk);
    bus.gameover = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_lw", {4'd0, bus.loser_wins}, 8'd0);
    check("midrst_ww", {4'd0, bus.winner_wins}, 8'd0);
    check("midrst_clr", {7'd0, bus.counter_clear}, 8'd1);
    repeat (4) @(negedge clk);
    check("midrst_idle", {7'd0, bus.counter_clear}, 8'd1);

`ifdef REFEREE_TIMEOUT_EN
    start_seq();
    repeat (15) @(negedge clk);
    check("wdog_early", {7'd0, bus.timeout}, 8'd0);
    @(negedge clk);
    check("wdog_flag", {7'd0, bus.timeout}, 8'd1);
    check("wdog_clr", {7'd0, bus.counter_clear}, 8'd1);
    check("wdog_lw", {4'd0, bus.loser_wins}, 8'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/game_referee.md
# game_referee

Match-level controller placed directly downstream of the multi-mode counter. It consumes the counter's `GAMEOVER`/`WHO` outputs and keeps a best-of-N tally of games won by each side. After every game it drives the counter's `clear` input and declares a match winner once one side reaches `GAMES_TO_WIN`. It is the only block that restarts games, so the counter never free-runs past a finished game.

## Interface
- `GAMES_TO_WIN`, 3: games needed to win the match; legal range 1–15.
- `CLEAR_CYCLES`, 2: cycles `counter_clear` is held after each game; must be ≥1.
- `TIMEOUT_CYCLES`, 1024: watchdog limit; used only when `REFEREE_TIMEOUT_EN` is defined.
- `clk` input 1: single clock; all logic on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `start_match` input 1: single-cycle request to begin a new match.
- `gameover` input 1: counter `GAMEOVER` (level; stays high until the counter is cleared).
- `who` input 2: counter `WHO`. 2'b01 = loser side won, 2'b10 = winner side won, 2'b00/2'b11 = invalid.
- `counter_clear` output 1: drives the counter `clear` input.
- `loser_wins` output 4: games won by the loser side in the current match.
- `winner_wins` output 4: games won by the winner side in the current match.
- `match_done` output 1: high while a decided match is held.
- `match_winner` output 2: `who` code of the match winner; 2'b00 while undecided.
- `bad_who` output 1: one-cycle pulse when a game ends with an invalid `who`.
- `timeout` output 1: sticky watchdog flag; exists only with `REFEREE_TIMEOUT_EN`.

## Operation
- States: IDLE, PLAY, CLEARING, DONE.
- Reset values: state = IDLE; `counter_clear` = 1 (the counter is held cleared while idle); tallies = 0; `match_done` = 0; `match_winner` = 2'b00; `bad_who` = 0; `timeout` = 0.
- **IDLE**: `counter_clear` stays high. On `start_match`: tallies ← 0, enter CLEARING.
- **PLAY**: `counter_clear` = 0. The block acts on the rising edge of `gameover`, detected against a registered copy of `gameover`.
  - Valid `who`: increment the matching tally by 1 and enter CLEARING.
  - Invalid `who`: pulse `bad_who`, leave tallies unchanged, enter CLEARING (the game is replayed).
- **CLEARING**: `counter_clear` = 1 for exactly `CLEAR_CYCLES` cycles, using a down-counter loaded on entry.
  - On exit, if either tally equals `GAMES_TO_WIN`, enter DONE and set `match_winner`.
  - Otherwise enter PLAY.
- **DONE**: `match_done` = 1 and `counter_clear` = 1. Tallies and `match_winner` are frozen. `start_match` clears `match_done` and `match_winner`, zeroes the tallies, and enters CLEARING.
- Boundary conditions:
  - `start_match` is ignored in PLAY and CLEARING.
  - `gameover` already high on entry to PLAY does not count, because the edge register is preloaded to 1 on entry.
  - A tally saturates at `GAMES_TO_WIN` and can never wrap.
  - `rst` has priority over every other input in every state. Reset mid-match discards the tallies.
  - Only one tally can change per game. Both sides cannot reach the limit together.

## Timing
- `gameover` rising edge at cycle N → tally update and `counter_clear` = 1 at N+1.
- `counter_clear` stays high for cycles N+1 … N+`CLEAR_CYCLES`.
- Then either PLAY (`counter_clear` low at N+`CLEAR_CYCLES`+1) or DONE (`match_done` high at N+`CLEAR_CYCLES`+1).
- `start_match` at cycle M (in IDLE or DONE) → CLEARING from M+1. `match_done` falls at M+1.
- All outputs are registered. No combinational input-to-output path.

## Configuration
- `REFEREE_TIMEOUT_EN` defined:
  - A watchdog counts PLAY cycles since the last game ended.
  - When the count reaches `TIMEOUT_CYCLES`, the block sets `timeout` (sticky until `rst` or `start_match`), counts no game, and enters CLEARING.
  - The watchdog is reset on every entry to PLAY.
- `REFEREE_TIMEOUT_EN` undefined: no watchdog logic, no `timeout` port, and PLAY waits indefinitely.

## Structure
- Shared `game_pkg` holds:
  - `who_t` enum (WHO_NONE = 2'b00, WHO_LOSER = 2'b01, WHO_WINNER = 2'b10, WHO_BAD = 2'b11).
  - `ref_state_t` enum.
  - Tally width constant (4).
- Sub-module `win_tally` holds one per-side saturating counter with sync clear and increment enable. It is instantiated twice.
- The state machine, edge detect, clear timer and watchdog stay in `game_referee`.

## Test plan
- Reset, then `start_match` → `counter_clear` high for 2 cycles then low; tallies 0/0; `match_done` = 0.
- Three `gameover` edges with `who` = 2'b10 → `winner_wins` = 3, `match_done` = 1, `match_winner` = 2'b10, `counter_clear` held high.
- Alternating 01/10 games ending 3–2 for the loser side → `loser_wins` = 3, `winner_wins` = 2, `match_winner` = 2'b01.
- `gameover` edge with `who` = 2'b11 → `bad_who` one-cycle pulse, tallies unchanged, clear pulse issued, PLAY resumes.
- `gameover` held high through CLEARING and into PLAY → no second count. `rst` asserted mid-CLEARING → IDLE, tallies 0.
- With `REFEREE_TIMEOUT_EN` and `TIMEOUT_CYCLES` = 16: no `gameover` for 16 PLAY cycles → `timeout` = 1, tallies unchanged, CLEARING entered.
